// File: rtl/stage2_decode.sv
// RV32I decode stage: combinational decode of the fetch beat into an output register
// backed by a skid register, so execute back-pressure never reaches fetch combinationally.
module stage2_decode #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_instruction,
    input  logic [WIDTH-1:0] s_program_counter,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_program_counter,
    output logic [WIDTH-1:0] m_instruction,
    output logic [4:0]       m_rd,
    output logic [4:0]       m_rs1,
    output logic [4:0]       m_rs2,
    output logic [2:0]       m_funct3,
    output logic             m_funct7_5,
    output logic [3:0]       m_op_class,
    output logic [WIDTH-1:0] m_imm,
    output logic             m_illegal
);

    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OPIMM   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd15
    } op_class_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       funct3;
        logic             funct7_5;
        op_class_e        op_class;
        logic [WIDTH-1:0] imm;
        logic             illegal;
    } beat_t;

    logic [31:0] ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    beat_t       dec;
    beat_t       out_q, skid_q;
    logic        out_valid, skid_valid;
    logic        out_valid_n, skid_valid_n;
    logic        load_out_from_skid, load_out_from_in, load_skid;
    logic        out_free, accept;

    assign ins   = s_instruction;
    assign f3    = ins[14:12];
    assign f7    = ins[31:25];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'h000};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch behind.
        dec          = '0;
        dec.pc       = s_program_counter;
        dec.instr    = ins;
        dec.rd       = ins[11:7];
        dec.rs1      = ins[19:15];
        dec.rs2      = ins[24:20];
        dec.funct3   = f3;
        dec.funct7_5 = ins[30];
        dec.op_class = CLS_ILLEGAL;
        dec.imm      = '0;
        dec.illegal  = 1'b0;
        unique case (ins[6:0])
            OPC_OP: begin
                dec.op_class = CLS_OP;
                dec.illegal  = !(f7 == 7'b0000000 || f7 == 7'b0100000)
                             || (ins[30] && !(f3 == 3'd0 || f3 == 3'd5));
            end
            OPC_OPIMM:  begin dec.op_class = CLS_OPIMM;  dec.imm = imm_i; end
            OPC_LOAD:   begin dec.op_class = CLS_LOAD;   dec.imm = imm_i; end
            OPC_STORE:  begin dec.op_class = CLS_STORE;  dec.imm = imm_s; end
            OPC_BRANCH: begin
                dec.op_class = CLS_BRANCH;
                dec.imm      = imm_b;
                dec.illegal  = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_JAL:    begin dec.op_class = CLS_JAL;    dec.imm = imm_j; end
            OPC_JALR: begin
                dec.op_class = CLS_JALR;
                dec.imm      = imm_i;
                dec.illegal  = (f3 != 3'd0);
            end
            OPC_LUI:    begin dec.op_class = CLS_LUI;    dec.imm = imm_u; end
            OPC_AUIPC:  begin dec.op_class = CLS_AUIPC;  dec.imm = imm_u; end
            OPC_FENCE:  dec.op_class = CLS_FENCE;
            OPC_SYSTEM: begin dec.op_class = CLS_SYSTEM; dec.imm = imm_i; end
            default:    dec.illegal = 1'b1;
        endcase
        // Malformed variants of known opcodes keep their decoded fields but report as illegal.
        if (dec.illegal) dec.op_class = CLS_ILLEGAL;
    end

    assign out_free = !out_valid || m_ready;
    assign accept   = s_valid && s_ready;

    always_comb begin
        out_valid_n        = out_valid;
        skid_valid_n       = skid_valid;
        load_out_from_skid = 1'b0;
        load_out_from_in   = 1'b0;
        load_skid          = 1'b0;
        if (flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_n        = 1'b1;
                load_out_from_skid = 1'b1;
                skid_valid_n       = accept;
                load_skid          = accept;
            end else begin
                out_valid_n      = accept;
                load_out_from_in = accept;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            load_skid    = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            s_ready    <= 1'b1;
            out_q      <= '0;
        end else begin
            out_valid  <= out_valid_n;
            skid_valid <= skid_valid_n;
            s_ready    <= !skid_valid_n;
            if (load_out_from_skid)    out_q <= skid_q;
            else if (load_out_from_in) out_q <= dec;
        end
    end

    // NOTE: skid payload has no reset; it is never observed unless skid_valid is set.
    always_ff @(posedge clk) begin
        if (load_skid) skid_q <= dec;
    end

    assign m_valid           = out_valid;
    assign m_program_counter = out_q.pc;
    assign m_instruction     = out_q.instr;
    assign m_rd              = out_q.rd;
    assign m_rs1             = out_q.rs1;
    assign m_rs2             = out_q.rs2;
    assign m_funct3          = out_q.funct3;
    assign m_funct7_5        = out_q.funct7_5;
    assign m_op_class        = out_q.op_class;
    assign m_imm             = out_q.imm;
    assign m_illegal         = out_q.illegal;

endmodule

// File: tb/tb_stage2_decode.sv
// Bench for stage2_decode: table-driven decode vectors, directed stall/flush/reset sequences
// and a random stream, all checked through an expected-beat queue.
module tb_stage2_decode;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, flush, m_valid, m_ready;
    logic [31:0] s_instruction, s_program_counter;
    logic [31:0] m_program_counter, m_instruction, m_imm;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [2:0]  m_funct3;
    logic        m_funct7_5, m_illegal;
    logic [3:0]  m_op_class;

    always #5 clk = ~clk;

    stage2_decode #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_instruction(s_instruction), .s_program_counter(s_program_counter),
        .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_program_counter(m_program_counter), .m_instruction(m_instruction),
        .m_rd(m_rd), .m_rs1(m_rs1), .m_rs2(m_rs2),
        .m_funct3(m_funct3), .m_funct7_5(m_funct7_5),
        .m_op_class(m_op_class), .m_imm(m_imm), .m_illegal(m_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  cls;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          out_count = 0;
    exp_t        q[$];
    exp_t        cur_exp;
    logic [31:0] out_pcs[$];
    logic        held = 1'b0;
    logic [31:0] held_pc, held_instr, held_imm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] sx;
        op = i[6:0];
        f3 = i[14:12];
        e.pc = pc; e.instr = i; e.imm = 32'h0; e.ill = 1'b0; e.cls = 4'd15;
        if (op == 7'b0110011) begin
            e.cls = 4'd0;
            e.ill = (i[31:25] != 7'h00 && i[31:25] != 7'h20) || (i[30] && f3 != 3'd0 && f3 != 3'd5);
        end else if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 || op == 7'b1110011) begin
            sx = 32'($signed(i) >>> 20);
            e.imm = sx;
            e.cls = (op == 7'b0010011) ? 4'd1 : (op == 7'b0000011) ? 4'd2 : (op == 7'b1100111) ? 4'd6 : 4'd10;
            if (op == 7'b1100111) e.ill = (f3 != 3'd0);
        end else if (op == 7'b0100011) begin
            sx = 32'($signed(i) >>> 25);
            e.imm = {sx[26:0], i[11:7]};
            e.cls = 4'd3;
        end else if (op == 7'b1100011) begin
            e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            e.cls = 4'd4;
            e.ill = (f3 == 3'd2 || f3 == 3'd3);
        end else if (op == 7'b1101111) begin
            e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            e.cls = 4'd5;
        end else if (op == 7'b0110111 || op == 7'b0010111) begin
            e.imm = i & 32'hFFFF_F000;
            e.cls = (op == 7'b0110111) ? 4'd7 : 4'd8;
        end else if (op == 7'b0001111) begin
            e.cls = 4'd9;
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) e.cls = 4'd15;
        return e;
    endfunction

    // Monitor: queue mirrors the beats held inside the DUT; sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            check("m_valid_vs_model", {31'd0, m_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
            check("s_ready_vs_model", {31'd0, s_ready}, (q.size() < 2) ? 32'd1 : 32'd0);
            if (held) begin
                check("hold_pc", m_program_counter, held_pc);
                check("hold_instr", m_instruction, held_instr);
                check("hold_imm", m_imm, held_imm);
            end
            if (m_valid && m_ready && q.size() > 0) begin
                e = q.pop_front();
                check("out_pc", m_program_counter, e.pc);
                check("out_instr", m_instruction, e.instr);
                check("out_class", {28'd0, m_op_class}, {28'd0, e.cls});
                check("out_imm", m_imm, e.imm);
                check("out_illegal", {31'd0, m_illegal}, {31'd0, e.ill});
                check("out_fields", {15'd0, m_rd, m_rs1, m_rs2, m_funct3, m_funct7_5},
                      {15'd0, e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12], e.instr[30]});
                out_pcs.push_back(m_program_counter);
                out_count++;
            end
            held       = m_valid && !m_ready && !flush;
            held_pc    = m_program_counter;
            held_instr = m_instruction;
            held_imm   = m_imm;
            if (flush) q.delete();
            else if (s_valid && s_ready) q.push_back(cur_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        s_valid           = 1'b1;
        s_instruction     = instr;
        s_program_counter = pc;
        cur_exp           = ref_decode(instr, pc);
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        flush   = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        check("drain_empty", q.size(), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcodes[11];
        logic [31:0] r;
        int          sel;
        opcodes = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                    7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
        r   = $urandom;
        sel = $urandom_range(0, 12);
        if (sel < 11) begin
            r[6:0] = opcodes[sel];
            if (sel == 0 && $urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return r;
    endfunction

    exp_t vecs[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx, cyc, accepted;
        logic        acc;
        logic [31:0] bp_pcs[5];

        vecs[0]  = '{32'h00, 32'hFFF10093, 4'd1,  32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h04, 32'hFE000CE3, 4'd4,  32'hFFFFFFF8, 1'b0};
        vecs[2]  = '{32'h08, 32'h123452B7, 4'd7,  32'h12345000, 1'b0};
        vecs[3]  = '{32'h40, 32'h0000006F, 4'd5,  32'h00000000, 1'b0};
        vecs[4]  = '{32'h44, 32'h00000000, 4'd15, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h48, 32'h40001033, 4'd15, 32'h00000000, 1'b1};
        vecs[6]  = '{32'h4C, 32'hFE112E23, 4'd3,  32'hFFFFFFFC, 1'b0};
        vecs[7]  = '{32'h50, 32'h00001067, 4'd15, 32'h00000000, 1'b1};
        vecs[8]  = '{32'h54, 32'h00002063, 4'd15, 32'h00000000, 1'b1};
        vecs[9]  = '{32'h58, 32'hFFFFF017, 4'd8,  32'hFFFFF000, 1'b0};
        vecs[10] = '{32'h5C, 32'hFFDFF06F, 4'd5,  32'hFFFFFFFC, 1'b0};
        vecs[11] = '{32'h60, 32'h0FF0000F, 4'd9,  32'h00000000, 1'b0};
        vecs[12] = '{32'h64, 32'h40000033, 4'd0,  32'h00000000, 1'b0};
        vecs[13] = '{32'h68, 32'h40105093, 4'd1,  32'h00000401, 1'b0};

        rst = 1'b1; s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
        s_instruction = 32'h0; s_program_counter = 32'h0; cur_exp = '0;
        repeat (3) tick();
        check("reset_m_valid", {31'd0, m_valid}, 32'd0);
        check("reset_s_ready", {31'd0, s_ready}, 32'd1);
        check("reset_m_imm", m_imm, 32'd0);
        check("reset_m_class", {28'd0, m_op_class}, 32'd0);
        check("reset_m_pc", m_program_counter, 32'd0);
        rst = 1'b0;
        tick();

        // Table: one beat per cycle, each must appear on the outputs the next cycle.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].instr, vecs[i].pc);
            cur_exp = vecs[i];
            tick();
            check("vec_m_valid", {31'd0, m_valid}, 32'd1);
            check("vec_pc", m_program_counter, vecs[i].pc);
            check("vec_class", {28'd0, m_op_class}, {28'd0, vecs[i].cls});
            check("vec_imm", m_imm, vecs[i].imm);
            check("vec_illegal", {31'd0, m_illegal}, {31'd0, vecs[i].ill});
            check("vec_rd", {27'd0, m_rd}, {27'd0, vecs[i].instr[11:7]});
            check("vec_rs1", {27'd0, m_rs1}, {27'd0, vecs[i].instr[19:15]});
        end
        drain();

        // Back-pressure: continuous stream while execute stalls for three cycles.
        bp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        out_pcs.delete();
        idx = 0; cyc = 0; acc = 1'b0;
        begin
            logic saw_not_ready;
            saw_not_ready = 1'b0;
            while (idx < 5 && cyc < 50) begin
                m_ready = !(cyc >= 1 && cyc <= 3);
                drive(32'h00000013 | (32'(idx + 1) << 20), bp_pcs[idx]);
                acc = s_ready;
                if (!s_ready) saw_not_ready = 1'b1;
                tick();
                if (acc) idx++;
                cyc++;
            end
            check("bp_all_sent", idx, 32'd5);
            check("bp_saw_not_ready", {31'd0, saw_not_ready}, 32'd1);
        end
        drain();
        check("bp_out_count", out_pcs.size(), 32'd5);
        for (int i = 0; i < 5 && i < out_pcs.size(); i++) check("bp_order", out_pcs[i], bp_pcs[i]);

        // Flush with output and skid both occupied.
        m_ready = 1'b0;
        drive(32'h00100093, 32'h10); tick();
        drive(32'h00200093, 32'h14); tick();
        check("flush_skid_full", {31'd0, s_ready}, 32'd0);
        drive(32'h00300093, 32'h18); flush = 1'b1; tick();
        flush = 1'b0; s_valid = 1'b0;
        check("flush_m_valid", {31'd0, m_valid}, 32'd0);
        check("flush_s_ready", {31'd0, s_ready}, 32'd1);
        m_ready = 1'b1;
        drive(32'h00400093, 32'h100); tick();
        s_valid = 1'b0;
        check("flush_next_valid", {31'd0, m_valid}, 32'd1);
        check("flush_next_pc", m_program_counter, 32'h100);
        drain();

        // Reset while stalled with skid full, then resume.
        m_ready = 1'b0;
        drive(32'h12345037, 32'h200); tick();
        drive(32'hFFF00013, 32'h204); tick();
        s_valid = 1'b0; rst = 1'b1; tick();
        check("rst_mid_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_mid_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_mid_m_imm", m_imm, 32'd0);
        rst = 1'b0; m_ready = 1'b1;
        drive(32'h00500113, 32'h300); tick();
        drive(32'h00A00063, 32'h304); tick();
        s_valid = 1'b0;
        check("rst_resume_pc", m_program_counter, 32'h304);
        check("rst_resume_imm", m_imm, 32'h00000000);
        drain();

        // Random stream with random back-pressure and flush.
        accepted = 0; cyc = 0;
        out_count = 0;
        while (accepted < 10000 && cyc < 60000) begin
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 9) < 7) drive(rand_instr(), $urandom & 32'hFFFF_FFFC);
            else s_valid = 1'b0;
            if (s_valid && s_ready && !flush) accepted++;
            tick();
            cyc++;
        end
        drain();
        check("random_beats_done", (accepted >= 10000) ? 32'd1 : 32'd0, 32'd1);
        check("random_outputs_seen", (out_count > 5000) ? 32'd1 : 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage2_decode.md
Name: stage2_decode

Overview:
RV32I decode stage, directly downstream of the fetch stage. It consumes {instruction, program_counter} beats and produces registered decoded fields for the execute stage: register indices, funct fields, operation class, sign-extended immediate and an illegal flag. A 2-entry elastic buffer (output register plus skid register) isolates execute back-pressure from fetch. A flush input from branch resolution discards all in-flight beats.

Parameters:
WIDTH, 32, data and program-counter width; only 32 is supported.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
s_valid  in  1  fetch beat valid.
s_ready  out  1  decode can accept a beat.
s_instruction  in  WIDTH  instruction word.
s_program_counter  in  WIDTH  PC of s_instruction.
flush  in  1  branch_taken from the resolving stage; kills in-flight beats.
m_valid  out  1  decoded beat valid.
m_ready  in  1  execute accepts the beat.
m_program_counter  out  WIDTH  PC of decoded instruction.
m_instruction  out  WIDTH  raw instruction, passed through.
m_rd  out  5  instr[11:7].
m_rs1  out  5  instr[19:15].
m_rs2  out  5  instr[24:20].
m_funct3  out  3  instr[14:12].
m_funct7_5  out  1  instr[30].
m_op_class  out  4  0 OP, 1 OPIMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 FENCE, 10 SYSTEM, 15 ILLEGAL.
m_imm  out  WIDTH  sign-extended immediate.
m_illegal  out  1  unrecognised encoding.

Behaviour:
- Reset: out_valid=0, skid_valid=0, s_ready=1 in the cycle after rst is seen high. All m_* data outputs are 0 and m_op_class is 0. Reset has priority over flush and handshakes. Reset mid-stream drops every held beat.
- Handshakes: input transfer when s_valid&&s_ready; output transfer when m_valid&&m_ready. m_* data stays stable while m_valid&&!m_ready.
- Latency: 1 cycle. A beat accepted in cycle N with the output register empty or draining appears on m_* in N+1.
- Decode logic is combinational on the incoming word. The result is stored in the output or skid register, so the skid entry holds already-decoded fields.
- Elastic buffer (next-state rules):
  * If the output register is empty or draining: it loads from skid if skid_valid (skid clears, and an accepted input beat moves into skid), else from the accepted input.
  * If the output register is held (m_valid&&!m_ready) and an input beat is accepted, the beat goes to skid.
  * s_ready is the registered value of !skid_valid_next, so there is no combinational path from m_ready to s_ready. There is no beat loss or duplication, and order is preserved.
- Flush: in the flush cycle, out_valid_next=0 and skid_valid_next=0, and any beat accepted in that same cycle is discarded. s_ready=1 in the next cycle. flush and m_ready together: the output beat counts as transferred and is not replayed.
- Op class: from opcode=instr[6:0]: 0110011 OP, 0010011 OPIMM, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, 0001111 FENCE, 1110011 SYSTEM. Any other value gives class 15 with m_illegal=1.
- Immediates (bit 31 sign-extends in every format):
  * I-type (OPIMM, LOAD, JALR, SYSTEM): instr[31:20].
  * S-type: {instr[31:25], instr[11:7]}.
  * B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  * U-type (LUI, AUIPC): {instr[31:12], 12'b0}.
  * J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  * OP, FENCE and ILLEGAL: imm=0.
- Illegal also for:
  * JALR with funct3!=0.
  * BRANCH with funct3 of 2 or 3.
  * OP with instr[31:25] not 0000000 or 0100000, or instr[30]=1 with funct3 not in {0,5}.
  In these cases the fields still decode and m_op_class=15.
- Register fields are always extracted raw, whatever the format.

Test Plan:
- Single beats, m_ready=1, one per cycle:
  * 0xFFF10093 -> next cycle m_valid=1, OPIMM, rd=1, rs1=2, imm=0xFFFFFFFF.
  * 0xFE000CE3 -> BRANCH, funct3=0, imm=0xFFFFFFF8.
  * 0x123452B7 -> LUI, rd=5, imm=0x12345000.
  * 0x0000006F at PC 0x40 -> JAL, imm=0, m_program_counter=0x40.
- Illegal encodings, one beat each: 0x00000000 -> m_illegal=1, class 15; 0x40001033 (sub with funct3=1) -> m_illegal=1.
- Back-pressure: s_valid=1 with PCs 0,4,8,C,10; m_ready=0 for cycles 2-4 -> s_ready=0 once skid fills; m_valid held stable; after release the output PCs are exactly 0,4,8,C,10 with no gaps or duplicates.
- Flush: two beats in flight (output plus skid) with PCs 0x10 and 0x14, flush=1 in the same cycle as s_valid with PC 0x18 -> next cycle m_valid=0, s_ready=1; the next accepted PC 0x100 is the first one output.
- Reset mid-operation: rst=1 while stalled with skid full -> next cycle m_valid=0, s_ready=1, m_imm=0; resumed stream decodes normally.
- Random stream with random m_ready/flush checked against a reference decoder and queue model -> no mismatch over 10k beats.
